// File: rtl/aes_block_loader.sv
// aes_block_loader
//   Byte-stream front end for an AES-128 cipher core. It assembles 16 ingress
//   bytes into one block, padding a short block with PAD_BYTE. It launches the
//   core and waits for the result, with a timeout. It then streams the 16
//   ciphertext bytes out. Only one block is in flight at a time.
//
// Ports
//   clk, rst_n                        clock, async active-low reset
//   in_valid/in_ready/in_data/in_last ingress byte stream (in_last ends a block)
//   key_load, key_in                  key capture request (only between blocks)
//   core_start                        one-cycle launch pulse to the core
//   core_plaintext, core_key          assembled block and held key
//   core_busy, core_done              core status / one-cycle result strobe
//   core_ciphertext                   core result
//   out_valid/out_ready/out_data      egress byte stream
//   out_last                          marks byte 15 of an egress block
//   timeout_err                       sticky: core failed to answer in time
//   block_count                       completed egress blocks (wraps)

// One plaintext byte slot. It loads either the ingress byte or the pad value.
module aes_block_loader_slot #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_data,
    input  logic       wr_pad,
    input  logic [7:0] data_in,
    output logic [7:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       q <= '0;
        else if (wr_data) q <= data_in;
        else if (wr_pad)  q <= PAD_BYTE;
    end
endmodule

module aes_block_loader #(
    parameter logic [7:0] PAD_BYTE       = 8'h00,
    parameter int         TIMEOUT_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         key_load,
    input  logic [127:0] key_in,
    output logic         core_start,
    output logic [127:0] core_plaintext,
    output logic [127:0] core_key,
    input  logic         core_busy,
    input  logic         core_done,
    input  logic [127:0] core_ciphertext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         out_last,
    output logic         timeout_err,
    output logic [15:0]  block_count
);
    typedef enum logic [1:0] {S_COLLECT, S_LAUNCH, S_WAIT, S_DRAIN} state_t;

    localparam logic [5:0] TMO = 6'(TIMEOUT_CYCLES);

    state_t             state, state_nxt;
    logic [3:0]         idx, oidx;
    logic [5:0]         timer;
    logic [127:0]       key_reg;
    // Element 15 holds byte 0, so the packed vector is already in wire order.
    logic [15:0][7:0]   pt_buf;
    logic [15:0][7:0]   ct_buf;

    logic accept, blk_end, out_xfer, timed_out;

    assign accept    = (state == S_COLLECT) && in_valid;
    assign blk_end   = accept && (in_last || idx == 4'd15);
    assign out_xfer  = (state == S_DRAIN) && out_ready;
    // core_done has priority over the timeout in the same cycle.
    assign timed_out = (state == S_WAIT) && !core_done && (timer == TMO);

    assign core_plaintext = pt_buf;
    assign core_key       = key_reg;

    // Byte s is written with data when it is the current slot. It is written
    // with pad when the block closes before reaching it.
    for (genvar s = 0; s < 16; s++) begin : g_slot
        aes_block_loader_slot #(.PAD_BYTE(PAD_BYTE)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_data (accept && (idx == 4'(s))),
            .wr_pad  (blk_end && (4'(s) > idx)),
            .data_in (in_data),
            .q       (pt_buf[15-s])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        core_start = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = 8'h00;
        case (state)
            S_COLLECT: begin
                in_ready = 1'b1;
                if (blk_end) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                if (!core_busy) begin
                    core_start = 1'b1;
                    state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (core_done)          state_nxt = S_DRAIN;
                else if (timer == TMO)  state_nxt = S_COLLECT;
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_data  = ct_buf[~oidx];   // ~oidx == 15-oidx for 4 bits
                out_last  = (oidx == 4'd15);
                if (out_ready && oidx == 4'd15) state_nxt = S_COLLECT;
            end
            default: state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            oidx        <= '0;
            timer       <= '0;
            key_reg     <= '0;
            ct_buf      <= '0;
            timeout_err <= 1'b0;
            block_count <= '0;
        end else begin
            if (accept) idx <= blk_end ? 4'd0 : idx + 4'd1;
            if (state == S_COLLECT && idx == 4'd0 && key_load) key_reg <= key_in;
            // The timer holds at zero outside WAIT, so it is clear on entry.
            timer <= (state == S_WAIT) ? timer + 6'd1 : 6'd0;
            if (state == S_WAIT && core_done) ct_buf <= core_ciphertext;
            if (timed_out) timeout_err <= 1'b1;
            if (out_xfer) begin
                oidx <= oidx + 4'd1;   // wraps to 0 after byte 15
                if (oidx == 4'd15) block_count <= block_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_aes_block_loader.sv
module tb_aes_block_loader;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0, rst_n;
    logic         in_valid, in_ready, in_last, key_load;
    logic [7:0]   in_data, out_data;
    logic [127:0] key_in, core_plaintext, core_key, core_ciphertext;
    logic         core_start, core_busy, core_done;
    logic         out_valid, out_ready, out_last, timeout_err;
    logic [15:0]  block_count;

    int n_cmp = 0, n_bad = 0;

    aes_block_loader dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .key_load(key_load), .key_in(key_in),
        .core_start(core_start), .core_plaintext(core_plaintext), .core_key(core_key),
        .core_busy(core_busy), .core_done(core_done), .core_ciphertext(core_ciphertext),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .timeout_err(timeout_err), .block_count(block_count)
    );

    always #5 clk = ~clk;

    // Behavioural core: 11-cycle latency, FIPS-197 answer for the FIPS vector,
    // plaintext ^ key otherwise. model_hold makes it ignore a launch.
    logic         model_hold = 1'b0, force_busy = 1'b0, force_done = 1'b0;
    int           m_cnt;
    logic         m_done;
    logic [127:0] m_ct;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0; m_done <= 1'b0; m_ct <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) m_done <= 1'b1;
            end else if (core_start && !model_hold) begin
                m_cnt <= 11;
                m_ct  <= (core_plaintext == FIPS_PT && core_key == FIPS_KEY)
                         ? FIPS_CT : (core_plaintext ^ core_key);
            end
        end
    end

    assign core_busy       = force_busy | (m_cnt != 0);
    assign core_done       = m_done | force_done;
    assign core_ciphertext = force_done ? 128'hdeadbeefdeadbeefdeadbeefdeadbeef : m_ct;

    task automatic send_byte(input logic [7:0] d, input logic l);
        int g = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l;
        #1;
        while (!in_ready && g < 100) begin @(negedge clk); #1; g++; end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_byte: in_ready stayed %b, required 1", in_ready);
        end
        @(posedge clk);
    endtask

    task automatic send_range(input logic [127:0] pt, input int from, input int to,
                              input logic last);
        for (int i = from; i <= to; i++) send_byte(pt[127-8*i -: 8], last && (i == to));
    endtask

    task automatic drain(input logic [127:0] exp, input logic toggle, input string nm);
        int         got = 0, g = 0;
        logic [7:0] held = 8'h00, eb;
        logic       stalled = 1'b0, el;
        out_ready = 1'b0;
        while (got < 16 && g < 400) begin
            @(negedge clk); g++;
            out_ready = toggle ? ~out_ready : 1'b1;
            #1;
            if (out_valid) begin
                if (stalled) begin
                    n_cmp++;
                    if (out_data !== held) begin
                        n_bad++;
                        $display("FAIL %s_hold: out_data %h, required %h", nm, out_data, held);
                    end
                end
                if (out_ready) begin
                    eb = exp[127-8*got -: 8];
                    el = (got == 15);
                    n_cmp++;
                    if (out_data !== eb || out_last !== el) begin
                        n_bad++;
                        $display("FAIL %s_byte%0d: data %h last %b, required %h last %b",
                                 nm, got, out_data, out_last, eb, el);
                    end
                    got++;
                    stalled = 1'b0;
                end else begin
                    held = out_data;
                    stalled = 1'b1;
                end
            end
        end
        n_cmp++;
        if (got != 16) begin
            n_bad++;
            $display("FAIL %s_count: %0d bytes, required 16", nm, got);
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, core_start, out_last, timeout_err} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_flags: {in_ready,out_valid,core_start,out_last,tmo} %b, required 10000",
                     {in_ready, out_valid, core_start, out_last, timeout_err});
        end
        n_cmp++;
        if (out_data !== 8'h00 || block_count !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_data: out_data %h block_count %h, required 00 0000", out_data, block_count);
        end
        n_cmp++;
        if (core_plaintext !== 128'h0 || core_key !== 128'h0) begin
            n_bad++;
            $display("FAIL reset_buf: pt %h key %h, required 0", core_plaintext, core_key);
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: in_ready %b, required 1", in_ready);
        end
    endtask

    // Reset in the middle of the egress stream, right after a power-on reset.
    task automatic test_reset_mid;
        logic [127:0] r = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        int   got = 0, g = 0;
        logic seen_v = 1'b0, seen_s = 1'b0;
        send_range(r, 0, 15, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        out_ready = 1'b1;
        while (got < 7 && g < 100) begin @(negedge clk); #1; g++; if (out_valid) got++; end
        @(negedge clk); #1;
        n_cmp++;
        if (got != 7 || out_valid !== 1'b1 || out_data !== r[127-56 -: 8]) begin
            n_bad++;
            $display("FAIL mid_byte7: valid %b data %h, required 1 %h", out_valid, out_data, r[127-56 -: 8]);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || block_count !== 16'h0000) begin
            n_bad++;
            $display("FAIL mid_reset: valid %b ready %b count %h, required 0 1 0000",
                     out_valid, in_ready, block_count);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (20) begin @(negedge clk); #1; seen_v |= out_valid; seen_s |= core_start; end
        n_cmp++;
        if (seen_v || seen_s || block_count !== 16'h0000) begin
            n_bad++;
            $display("FAIL mid_after: out_valid seen %b start seen %b count %h, required 0 0 0000",
                     seen_v, seen_s, block_count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_fips;
        @(negedge clk); key_load = 1'b1; key_in = FIPS_KEY;
        @(negedge clk); key_load = 1'b0;
        send_range(FIPS_PT, 0, 15, 1'b0);
        @(negedge clk); in_valid = 1'b0; #1;
        n_cmp++;
        if (core_start !== 1'b1 || core_plaintext !== FIPS_PT || core_key !== FIPS_KEY) begin
            n_bad++;
            $display("FAIL fips_launch: start %b pt %h key %h, required 1 %h %h",
                     core_start, core_plaintext, core_key, FIPS_PT, FIPS_KEY);
        end
        drain(FIPS_CT, 1'b0, "fips");
        n_cmp++;
        if (block_count !== 16'd1 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL fips_count: count %0d ready %b, required 1 1", block_count, in_ready);
        end
    endtask

    task automatic test_short;
        logic [127:0] pt = 128'haabbcc00000000000000000000000000;
        send_range(pt, 0, 2, 1'b1);
        @(negedge clk); in_valid = 1'b0; #1;
        n_cmp++;
        if (core_start !== 1'b1 || core_plaintext !== pt) begin
            n_bad++;
            $display("FAIL short_launch: start %b pt %h, required 1 %h", core_start, core_plaintext, pt);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (core_start !== 1'b0) begin
            n_bad++;
            $display("FAIL short_pulse: start %b one cycle later, required 0", core_start);
        end
        drain(pt ^ FIPS_KEY, 1'b1, "short");
        n_cmp++;
        if (block_count !== 16'd2) begin
            n_bad++;
            $display("FAIL short_count: %0d, required 2", block_count);
        end
    endtask

    task automatic test_busy;
        logic [127:0] pt = 128'hfedcba98765432100123456789abcdef;
        force_busy = 1'b1;
        send_range(pt, 0, 15, 1'b1);   // in_last on byte 15 is a plain full block
        @(negedge clk); in_valid = 1'b0; #1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin @(negedge clk); #1; end
            n_cmp++;
            if (core_start !== 1'b0 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL busy_hold%0d: start %b ready %b, required 0 0", c, core_start, in_ready);
            end
        end
        @(negedge clk); force_busy = 1'b0; #1;
        n_cmp++;
        if (core_start !== 1'b1 || core_plaintext !== pt) begin
            n_bad++;
            $display("FAIL busy_release: start %b pt %h, required 1 %h", core_start, core_plaintext, pt);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (core_start !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_pulse: start %b, required 0", core_start);
        end
        drain(pt ^ FIPS_KEY, 1'b1, "busy");
        n_cmp++;
        if (block_count !== 16'd3) begin
            n_bad++;
            $display("FAIL busy_count: %0d, required 3", block_count);
        end
    endtask

    task automatic test_last0;
        logic [127:0] pt = 128'h5a000000000000000000000000000000;
        send_range(pt, 0, 0, 1'b1);
        @(negedge clk); in_valid = 1'b0; #1;
        n_cmp++;
        if (core_start !== 1'b1 || core_plaintext !== pt) begin
            n_bad++;
            $display("FAIL last0_launch: start %b pt %h, required 1 %h", core_start, core_plaintext, pt);
        end
        drain(pt ^ FIPS_KEY, 1'b0, "last0");
        n_cmp++;
        if (block_count !== 16'd4) begin
            n_bad++;
            $display("FAIL last0_count: %0d, required 4", block_count);
        end
    endtask

    task automatic test_timeout;
        int   g = 0;
        logic seen_v = 1'b0;
        model_hold = 1'b1;
        send_range(128'h11111111222222223333333344444444, 0, 15, 1'b0);
        @(negedge clk); in_valid = 1'b0; #1;
        n_cmp++;
        if (core_start !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_launch: start %b, required 1", core_start);
        end
        repeat (32) @(negedge clk);
        #1;
        n_cmp++;
        if (timeout_err !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_early: err %b ready %b after 32 WAIT cycles, required 0 0", timeout_err, in_ready);
        end
        while (!timeout_err && g < 4) begin @(negedge clk); #1; g++; end
        n_cmp++;
        if (timeout_err !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_set: err %b ready %b valid %b, required 1 1 0", timeout_err, in_ready, out_valid);
        end
        model_hold = 1'b0;
        @(negedge clk); force_done = 1'b1;
        @(negedge clk); force_done = 1'b0;
        out_ready = 1'b1;
        repeat (20) begin @(negedge clk); #1; seen_v |= out_valid; end
        out_ready = 1'b0;
        n_cmp++;
        if (seen_v || block_count !== 16'd4 || timeout_err !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_late_done: valid seen %b count %0d err %b, required 0 4 1",
                     seen_v, block_count, timeout_err);
        end
    endtask

    task automatic test_key_ignore;
        logic [127:0] pt = 128'h0123456789abcdeffedcba9876543210;
        send_range(pt, 0, 4, 1'b0);
        @(negedge clk); in_valid = 1'b0; key_load = 1'b1; key_in = {16{8'hff}};
        @(negedge clk); key_load = 1'b0;
        send_range(pt, 5, 15, 1'b0);
        @(negedge clk); in_valid = 1'b0; #1;
        n_cmp++;
        if (core_key !== FIPS_KEY || core_plaintext !== pt) begin
            n_bad++;
            $display("FAIL key_ignore: key %h pt %h, required %h %h", core_key, core_plaintext, FIPS_KEY, pt);
        end
        drain(pt ^ FIPS_KEY, 1'b0, "keyign");
        n_cmp++;
        if (block_count !== 16'd5 || timeout_err !== 1'b1) begin
            n_bad++;
            $display("FAIL key_count: count %0d err %b, required 5 1", block_count, timeout_err);
        end
    endtask

    task automatic test_err_clear;
        @(negedge clk); rst_n = 1'b0; #1;
        n_cmp++;
        if (timeout_err !== 1'b0 || block_count !== 16'h0000) begin
            n_bad++;
            $display("FAIL err_clear: err %b count %h, required 0 0000", timeout_err, block_count);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        key_load = 1'b0; key_in = '0; out_ready = 1'b0;
        test_reset;
        test_reset_mid;
        test_fips;
        test_short;
        test_busy;
        test_last0;
        test_timeout;
        test_key_ignore;
        test_err_clear;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
